// File: rtl/vga_pattern_streamer.sv
`default_nettype none
// ============================================================================
// Module      : vga_pattern_streamer
// Description : Streams full frames of generated test patterns (colour bars,
//               checkerboard, gradient, solid) over a valid/ready pixel
//               interface with start/end-of-frame markers.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pattern_streamer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [23:0] solid_rgb,
    input  logic        src_ready,
    output logic        src_valid,
    output logic [23:0] src_data,
    output logic        src_sop,
    output logic        src_eop,
    output logic [15:0] frame_count
);

    // Counters are at least as wide as the gradient/checkerboard bit picks need.
    localparam int c_XW = ($clog2(H_ACTIVE) < 10) ? 10 : $clog2(H_ACTIVE);
    localparam int c_YW = ($clog2(V_ACTIVE) < 9)  ? 9  : $clog2(V_ACTIVE);
    localparam logic [c_XW-1:0] c_X_LAST   = c_XW'(H_ACTIVE - 1);
    localparam logic [c_YW-1:0] c_Y_LAST   = c_YW'(V_ACTIVE - 1);
    localparam logic [c_XW-1:0] c_BAR_W    = c_XW'((H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1);
    localparam logic            c_ONE_PIXEL = (H_ACTIVE == 1) && (V_ACTIVE == 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t            r_state;
    logic              r_armed;
    logic [c_XW-1:0]   r_x;
    logic [c_YW-1:0]   r_y;
    logic [1:0]        r_pat;
    logic [23:0]       r_solid;

    logic              w_x_wrap;
    logic              w_last;
    logic [c_XW-1:0]   w_nx;
    logic [c_YW-1:0]   w_ny;
    logic [15:0]       w_fc_next;

    function automatic logic [23:0] pixel_at(
        input logic [1:0]      pat,
        input logic [c_XW-1:0] px,
        input logic [c_YW-1:0] py,
        input logic [7:0]      fc,
        input logic [23:0]     solid
    );
        logic [c_XW-1:0] bar;
        logic [2:0]      idx;
        logic [23:0]     rgb;
        bar = px / c_BAR_W;
        idx = (bar > c_XW'(7)) ? 3'd7 : bar[2:0];
        case (pat)
            2'd0: begin
                case (idx)
                    3'd0:    rgb = 24'hFFFFFF;
                    3'd1:    rgb = 24'hFFFF00;
                    3'd2:    rgb = 24'h00FFFF;
                    3'd3:    rgb = 24'h00FF00;
                    3'd4:    rgb = 24'hFF00FF;
                    3'd5:    rgb = 24'hFF0000;
                    3'd6:    rgb = 24'h0000FF;
                    default: rgb = 24'h000000;
                endcase
            end
            2'd1:    rgb = (px[5] ^ py[5]) ? 24'hFFFFFF : 24'h000000;
            2'd2:    rgb = {px[9:2], py[8:1], fc};
            default: rgb = solid;
        endcase
        return rgb;
    endfunction

    assign w_x_wrap  = (r_x == c_X_LAST);
    assign w_last    = w_x_wrap && (r_y == c_Y_LAST);
    assign w_nx      = w_x_wrap ? '0 : r_x + c_XW'(1);
    assign w_ny      = w_x_wrap ? r_y + c_YW'(1) : r_y;
    assign w_fc_next = frame_count + 16'd1;

    // src_data always carries the pixel for the (x,y) currently presented, so
    // each update computes the pixel of the coordinate being moved to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_armed     <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_pat       <= 2'd0;
            r_solid     <= 24'h0;
            src_valid   <= 1'b0;
            src_sop     <= 1'b0;
            src_eop     <= 1'b0;
            src_data    <= 24'h0;
            frame_count <= 16'h0;
        end else begin
            r_armed <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (r_armed && enable) begin
                        r_state   <= STREAM;
                        r_pat     <= pattern_sel;
                        r_solid   <= solid_rgb;
                        r_x       <= '0;
                        r_y       <= '0;
                        src_valid <= 1'b1;
                        src_sop   <= 1'b1;
                        src_eop   <= c_ONE_PIXEL;
                        src_data  <= pixel_at(pattern_sel, c_XW'(0), c_YW'(0),
                                              frame_count[7:0], solid_rgb);
                    end else begin
                        src_valid <= 1'b0;
                        src_sop   <= 1'b0;
                        src_eop   <= 1'b0;
                    end
                end
                STREAM: begin
                    if (src_ready) begin
                        if (w_last) begin
                            frame_count <= w_fc_next;
                            r_x         <= '0;
                            r_y         <= '0;
                            if (enable) begin
                                r_pat    <= pattern_sel;
                                r_solid  <= solid_rgb;
                                src_sop  <= 1'b1;
                                src_eop  <= c_ONE_PIXEL;
                                src_data <= pixel_at(pattern_sel, c_XW'(0), c_YW'(0),
                                                     w_fc_next[7:0], solid_rgb);
                            end else begin
                                r_state   <= IDLE;
                                src_valid <= 1'b0;
                                src_sop   <= 1'b0;
                                src_eop   <= 1'b0;
                            end
                        end else begin
                            r_x      <= w_nx;
                            r_y      <= w_ny;
                            src_sop  <= 1'b0;
                            src_eop  <= (w_nx == c_X_LAST) && (w_ny == c_Y_LAST);
                            src_data <= pixel_at(r_pat, w_nx, w_ny, frame_count[7:0], r_solid);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_pattern_streamer
// Description : Randomized self-checking bench for vga_pattern_streamer with a
//               frame-level reference model, plus a 1x1 frame counter-wrap run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_pattern_streamer;

    localparam int H = 64;
    localparam int V = 40;
    localparam int N = H * V;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic [23:0] solid_rgb;
    logic        src_ready;
    logic        src_valid;
    logic [23:0] src_data;
    logic        src_sop;
    logic        src_eop;
    logic [15:0] frame_count;

    logic        wr_reset_n;
    logic        wr_enable;
    logic [1:0]  wr_pattern_sel;
    logic [23:0] wr_solid_rgb;
    logic        wr_ready;
    logic        wr_valid;
    logic [23:0] wr_data;
    logic        wr_sop;
    logic        wr_eop;
    logic [15:0] wr_frame_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #10 clk = ~clk;

    vga_pattern_streamer #(.H_ACTIVE(H), .V_ACTIVE(V)) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .solid_rgb   (solid_rgb),
        .src_ready   (src_ready),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .src_sop     (src_sop),
        .src_eop     (src_eop),
        .frame_count (frame_count)
    );

    vga_pattern_streamer #(.H_ACTIVE(1), .V_ACTIVE(1)) u_dut_wrap (
        .clk         (clk),
        .reset_n     (wr_reset_n),
        .enable      (wr_enable),
        .pattern_sel (wr_pattern_sel),
        .solid_rgb   (wr_solid_rgb),
        .src_ready   (wr_ready),
        .src_valid   (wr_valid),
        .src_data    (wr_data),
        .src_sop     (wr_sop),
        .src_eop     (wr_eop),
        .frame_count (wr_frame_count)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: frame position as a beat index, latched frame settings.
    bit          m_armed;
    bit          m_run;
    int          m_beat;
    int          m_pat;
    logic [23:0] m_solid;
    int          m_fc;
    int          xfers;

    function automatic logic [23:0] ref_pixel(int pat, int x, int y, int fc, logic [23:0] solid);
        int b;
        logic [7:0] r, g, bl;
        case (pat)
            0: begin
                b = x / (H / 8);
                case (b)
                    0:       return 24'hFFFFFF;
                    1:       return 24'hFFFF00;
                    2:       return 24'h00FFFF;
                    3:       return 24'h00FF00;
                    4:       return 24'hFF00FF;
                    5:       return 24'hFF0000;
                    6:       return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            1: return ((((x / 32) + (y / 32)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
            2: begin
                r  = 8'((x / 4) % 256);
                g  = 8'((y / 2) % 256);
                bl = 8'(fc % 256);
                return {r, g, bl};
            end
            default: return solid;
        endcase
    endfunction

    function automatic logic [42:0] ref_outs();
        logic [23:0] d;
        d = m_run ? ref_pixel(m_pat, m_beat % H, m_beat / H, m_fc, m_solid) : 24'h0;
        return {m_run, m_run && (m_beat == 0), m_run && (m_beat == N - 1), d, 16'(m_fc)};
    endfunction

    function automatic logic [42:0] dut_outs();
        return {src_valid, src_sop, src_eop, (m_run ? src_data : 24'h0), frame_count};
    endfunction

    task automatic model_step();
        if (!m_armed) begin
            m_armed = 1;
        end else if (!m_run) begin
            if (enable) begin
                m_run = 1; m_beat = 0; m_pat = int'(pattern_sel); m_solid = solid_rgb;
            end
        end else if (src_ready) begin
            if (m_beat == N - 1) begin
                m_fc = (m_fc + 1) % 65536;
                if (enable) begin
                    m_beat = 0; m_pat = int'(pattern_sel); m_solid = solid_rgb;
                end else begin
                    m_run = 0;
                end
            end else begin
                m_beat++;
            end
        end
    endtask

    task automatic tick();
        if (src_valid && src_ready) begin
            if (src_sop) xfers = 0;
            xfers++;
            if (src_eop) check_val("xfers_per_frame", 64'(xfers), 64'(N));
        end
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_val("beat", 64'(dut_outs()), 64'(ref_outs()));
    endtask

    task automatic run_to(input int beat, input bit rnd);
        int k;
        k = 0;
        while (!(m_run && m_beat == beat)) begin
            src_ready = rnd ? 1'($urandom % 2) : 1'b1;
            tick();
            k++;
            if (k > 4 * N) begin
                check_val("run_to_timeout", 64'(k), 64'(beat));
                return;
            end
        end
    endtask

    task automatic main_seq();
        reset_n = 1'b0; enable = 1'b1; pattern_sel = 2'd0; solid_rgb = 24'h0; src_ready = 1'b1;
        m_armed = 0; m_run = 0; m_beat = 0; m_pat = 0; m_solid = 24'h0; m_fc = 0; xfers = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_outputs", {src_valid, src_sop, src_eop, src_data, frame_count}, 64'h0);

        reset_n = 1'b1;
        tick();
        check_val("no_valid_first_edge", 64'(src_valid), 64'h0);
        tick();
        check_val("first_beat", {src_valid, src_sop, src_data}, {1'b1, 1'b1, 24'hFFFFFF});
        run_to(H / 8, 0);
        check_val("bar1_pixel", 64'(src_data), 64'hFFFF00);
        run_to(N - 1, 0);
        check_val("eop_last_beat", {src_valid, src_eop, src_sop}, {1'b1, 1'b1, 1'b0});
        src_ready = 1'b1;
        tick();
        check_val("frame_count_1", 64'(frame_count), 64'd1);
        check_val("no_bubble_sop", {src_valid, src_sop}, 2'b11);

        // Random backpressure across a whole frame.
        run_to(N - 1, 1);
        src_ready = 1'b1;
        tick();
        check_val("frame_count_2", 64'(frame_count), 64'd2);

        // Pattern change mid-frame must wait for the boundary.
        run_to(20 * H + 20, 1);
        pattern_sel = 2'd1;
        run_to(20 * H + 40, 1);
        check_val("bars_kept", 64'(src_data), 64'hFF0000);
        run_to(N - 1, 1);
        src_ready = 1'b1;
        tick();
        run_to(32, 1);
        check_val("checker_32_0", 64'(src_data), 64'hFFFFFF);
        run_to(32 * H + 32, 1);
        check_val("checker_32_32", 64'(src_data), 64'h000000);

        // Drop enable mid-frame; frame still completes.
        enable = 1'b0;
        pattern_sel = 2'd2;
        run_to(N - 1, 1);
        check_val("eop_after_disable", 64'(src_eop), 64'h1);
        src_ready = 1'b1;
        tick();
        check_val("idle_after_eop", {src_valid, src_sop, src_eop}, 3'b000);
        repeat (5) tick();
        enable = 1'b1;
        tick();
        check_val("restart_sop", {src_valid, src_sop}, 2'b11);

        // Asynchronous reset mid-frame.
        run_to(20 * H + 30, 1);
        reset_n = 1'b0;
        #1;
        check_val("async_clear", {src_valid, src_sop, src_eop, src_data, frame_count}, 64'h0);
        m_armed = 0; m_run = 0; m_beat = 0; m_fc = 0; xfers = 0;
        @(posedge clk);
        @(negedge clk);
        check_val("held_clear", {src_valid, src_eop, frame_count}, 64'h0);
        reset_n = 1'b1;
        src_ready = 1'b1;
        tick();
        tick();
        check_val("post_reset_start", {src_valid, src_sop, frame_count}, {1'b1, 1'b1, 16'h0});

        pattern_sel = 2'd3;
        solid_rgb = 24'($urandom);
        run_to(N - 1, 1);
        src_ready = 1'b1;
        tick();
        run_to(N - 1, 1);
        enable = 1'b0;
        src_ready = 1'b1;
        tick();
        check_val("final_count", 64'(frame_count), 64'd2);
    endtask

    task automatic wrap_seq();
        wr_reset_n = 1'b0; wr_enable = 1'b1; wr_pattern_sel = 2'd2;
        wr_solid_rgb = 24'h123456; wr_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        wr_reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("wrap_arm", 64'(wr_valid), 64'h0);
        @(posedge clk);
        @(negedge clk);
        check_val("wrap_first", {wr_valid, wr_sop, wr_eop, wr_data, wr_frame_count}, 64'h7_000000_0000);
        for (int n = 1; n <= 65537; n++) begin
            @(posedge clk);
            @(negedge clk);
            check_val("wrap_beat", {wr_valid, wr_sop, wr_eop, wr_data, wr_frame_count},
                      {3'b111, 16'h0, 8'(n % 256), 16'(n % 65536)});
            if (n == 65535) check_val("count_ffff", 64'(wr_frame_count), 64'hFFFF);
            if (n == 65536) begin
                check_val("count_wrap", 64'(wr_frame_count), 64'h0);
                check_val("wrap_b_byte", 64'(wr_data[7:0]), 64'h0);
            end
        end
    endtask

    initial begin
        fork
            main_seq();
            wrap_seq();
        join
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_pattern_streamer.md
VGA_PATTERN_STREAMER -- requirements
Module: vga_pattern_streamer

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, meaning active lines per frame.
REQ-003 SHALL have port clk  input  1  the single system clock (50 MHz); all logic is in this domain.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  streaming permitted; sampled only at frame start.
REQ-006 SHALL have port pattern_sel  input  2  pattern code; sampled only at frame start.
REQ-007 SHALL have port solid_rgb  input  24  {R,G,B} for pattern 3; sampled only at frame start.
REQ-008 SHALL have port src_ready  input  1  downstream (VGA pixel buffer) accepts a beat.
REQ-009 SHALL have port src_valid  output  1  beat present on src_data.
REQ-010 SHALL have port src_data  output  24  pixel {R[7:0],G[7:0],B[7:0]}.
REQ-011 SHALL have port src_sop  output  1  first pixel of frame, pixel (0,0).
REQ-012 SHALL have port src_eop  output  1  last pixel of frame, pixel (H_ACTIVE-1,V_ACTIVE-1).
REQ-013 SHALL have port frame_count  output  16  completed frames, modulo 2^16.

Function
REQ-014 SHALL implement FSM states IDLE and STREAM.
REQ-015 In IDLE with enable=1, SHALL latch pattern_sel and solid_rgb, set x=0/y=0, and enter STREAM next cycle with src_valid=1 and src_sop=1.
REQ-016 In IDLE with enable=0, SHALL hold src_valid=0 and remain in IDLE.
REQ-017 A beat SHALL transfer only on a cycle where src_valid=1 and src_ready=1 (ready latency 0).
REQ-018 While src_valid=1 and src_ready=0, src_data, src_sop and src_eop SHALL remain stable.
REQ-019 Each transfer SHALL advance x; at x=H_ACTIVE-1, x wraps to 0 and y increments.
REQ-020 On the transfer with x=H_ACTIVE-1 and y=V_ACTIVE-1 (src_eop=1), frame_count SHALL increment (wrap 0xFFFF->0x0000), x and y SHALL reset to 0, and enable SHALL be evaluated.
REQ-021 At the REQ-020 frame boundary with enable=1, SHALL relatch pattern_sel/solid_rgb and present pixel (0,0) with src_sop=1 on the next cycle, with no bubble.
REQ-022 At the REQ-020 frame boundary with enable=0, SHALL go to IDLE with src_valid=0 on the next cycle.
REQ-023 enable, pattern_sel and solid_rgb changes mid-frame SHALL have no effect until the next frame boundary.
REQ-024 src_sop SHALL be 1 only for pixel (0,0), and src_eop SHALL be 1 only for pixel (H_ACTIVE-1,V_ACTIVE-1).
REQ-025 Pattern 0 (colour bars) SHALL divide x into 8 bars of H_ACTIVE/8 px: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
REQ-026 Pattern 1 (checkerboard) SHALL output FFFFFF when x[5]^y[5]=1, else 000000.
REQ-027 Pattern 2 (gradient) SHALL output R=x[9:2], G=y[8:1], B=frame_count[7:0] as at frame start.
REQ-028 Pattern 3 (solid) SHALL output the latched solid_rgb.
REQ-029 src_data SHALL be registered; the pixel on src_data SHALL correspond to the current x,y (no additional pipeline latency visible at the port).

Reset
REQ-030 While reset_n=0, SHALL force IDLE, src_valid=0, src_sop=0, src_eop=0, src_data=0, frame_count=0, x=0, y=0, and latched pattern=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately with no src_eop; after release the next frame SHALL start at (0,0) with src_sop=1.
REQ-032 The first possible src_valid=1 after reset release SHALL be the second rising clk edge after release, with enable=1.

Verification
REQ-033 Reset release, enable=1, pattern_sel=0, src_ready=1 -> src_valid rises with src_sop=1 and src_data=FFFFFF; pixel 80 = FFFF00; src_eop occurs on beat 307200; frame_count=1.
REQ-034 Random src_ready backpressure (50%) over one full frame -> src_data, src_sop and src_eop are stable while stalled; exactly 307200 transfers per frame; pixel order matches the scoreboard.
REQ-035 pattern_sel changed 0->1 at pixel (100,100) -> the rest of the frame stays colour bars; the next frame's pixel (32,0) = FFFFFF and (32,32) = 000000.
REQ-036 enable dropped mid-frame -> the frame completes through src_eop; src_valid=0 the next cycle; re-raising enable restarts at (0,0) with src_sop=1.
REQ-037 reset_n pulsed low at pixel (300,200) -> outputs cleared asynchronously, no src_eop, frame_count=0; the next frame starts at (0,0).
REQ-038 pattern 2 with frame_count preset to 0xFFFF via 65535 short frames (H_ACTIVE=4, V_ACTIVE=2) -> frame_count wraps to 0x0000; pixel (0,0) B byte equals the latched count.
